// File: rtl/incdec_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | incdec_counter_bank : round-robin bank of wrap-around counters sharing    |
// |                       one prefix incrementer/decrementer                  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+

package lau_pkg;
  typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_e;
endpackage

module IncDec #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [width-1:0] A,
  input  logic             DEC,
  output logic [width-1:0] Z
);

  // A bit passes the carry/borrow when it is 1 (increment) or 0 (decrement).
  logic [width-2:0] w_prop;
  logic [width-2:0] w_pre;

  assign w_prop = A[width-2:0] ^ {(width-1){DEC}};

  if (speed == lau_pkg::FAST) begin : g_fast
    always_comb begin
      logic [width-2:0] lvl;
      lvl = w_prop;
      // In-place Kogge-Stone: descending i keeps lvl[i-s] at its previous-level value.
      for (int s = 1; s < width - 1; s = s * 2) begin
        for (int i = width - 2; i >= s; i--) begin
          lvl[i] = lvl[i] & lvl[i-s];
        end
      end
      w_pre = lvl;
    end
  end else begin : g_slow
    always_comb begin
      logic [width-2:0] chain;
      chain    = w_prop;
      for (int i = 1; i < width - 1; i++) begin
        chain[i] = chain[i-1] & w_prop[i];
      end
      w_pre = chain;
    end
  end

  assign Z = A ^ {w_pre, 1'b1};

endmodule

module incdec_counter_bank #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST,
  parameter int              nreq  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic [nreq-1:0]           req_valid_i,
  input  logic [nreq-1:0]           req_dec_i,
  output logic [nreq-1:0]           req_ready_o,
  output logic [nreq*width-1:0]     cnt_o,
  output logic                      rsp_valid_o,
  output logic [$clog2(nreq)-1:0]   rsp_id_o,
  output logic [width-1:0]          rsp_value_o,
  output logic                      rsp_wrap_o
);

  localparam int iw = $clog2(nreq);

  logic [width-1:0] r_cnt [nreq];
  logic [iw-1:0]    r_ptr;
  logic             r_rsp_valid;
  logic [iw-1:0]    r_rsp_id;
  logic [width-1:0] r_rsp_value;
  logic             r_rsp_wrap;

  logic             w_gnt_any;
  logic [iw-1:0]    w_gnt_id;
  logic [nreq-1:0]  w_gnt_oh;
  logic [iw-1:0]    w_ptr_nxt;
  logic [width-1:0] w_a;
  logic [width-1:0] w_z;
  logic             w_dec;
  logic             w_wrap;

  // First asserted valid scanning ptr, ptr+1, ... with wrap at nreq.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = 0; k < nreq; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!w_gnt_any && req_valid_i[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = idx[iw-1:0];
      end
    end
    if (clr_i) w_gnt_any = 1'b0;
  end

  always_comb begin
    w_gnt_oh = '0;
    if (w_gnt_any) w_gnt_oh[w_gnt_id] = 1'b1;
  end

  assign req_ready_o = w_gnt_oh;
  assign w_ptr_nxt   = (w_gnt_id == iw'(nreq - 1)) ? '0 : w_gnt_id + iw'(1);

  assign w_a    = r_cnt[w_gnt_id];
  assign w_dec  = req_dec_i[w_gnt_id];
  assign w_wrap = w_dec ? (w_a == '0) : (&w_a);

  IncDec #(
    .width (width),
    .speed (speed)
  ) u_incdec (
    .A   (w_a),
    .DEC (w_dec),
    .Z   (w_z)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < nreq; i++) r_cnt[i] <= '0;
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_value <= '0;
      r_rsp_wrap  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_value <= '0;
      r_rsp_wrap  <= 1'b0;
      if (clr_i) begin
        for (int i = 0; i < nreq; i++) r_cnt[i] <= '0;
      end else if (w_gnt_any) begin
        r_cnt[w_gnt_id] <= w_z;
        r_ptr           <= w_ptr_nxt;
        r_rsp_valid     <= 1'b1;
        r_rsp_id        <= w_gnt_id;
        r_rsp_value     <= w_z;
        r_rsp_wrap      <= w_wrap;
      end
    end
  end

  for (genvar i = 0; i < nreq; i++) begin : g_pack
    assign cnt_o[i*width +: width] = r_cnt[i];
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_value_o = r_rsp_value;
  assign rsp_wrap_o  = r_rsp_wrap;

endmodule
`default_nettype wire

// File: tb/tb_incdec_counter_bank.sv
`default_nettype none
// Testbench for incdec_counter_bank: directed vector table, async-reset
// sequence and a randomized run against a reference model.

module tb_incdec_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  valid;
  logic [3:0]  dec;
  logic [3:0]  ready;
  logic [31:0] cnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_value;
  logic        rsp_wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  incdec_counter_bank #(
    .width (8),
    .nreq  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .req_valid_i (valid),
    .req_dec_i   (dec),
    .req_ready_o (ready),
    .cnt_o       (cnt),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_value_o (rsp_value),
    .rsp_wrap_o  (rsp_wrap)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  dec;
    logic        clr;
    logic [3:0]  ready;
    logic        rv;
    logic [1:0]  id;
    logic [7:0]  val;
    logic        wrap;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // random-phase model state
  logic [3:0] pend, pdec, expr;
  logic [7:0] mcnt [4];
  int         wt [4];
  int         mptr, eg, idx, gid;
  bit         gflag;
  logic       exp_rv, exp_wrap;
  logic [1:0] exp_id;
  logic [7:0] exp_val;

  initial begin
    // valid  dec   clr   ready  rv  id  val    wrap cnt{c3,c2,c1,c0}
    tbl[0]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0, 32'h00000000};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h01, 1'b0, 32'h00000100};
    tbl[2]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h02, 1'b0, 32'h00000200};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd1, 8'h03, 1'b0, 32'h00000300};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd2, 8'h01, 1'b0, 32'h00010300};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd3, 8'h01, 1'b0, 32'h01010300};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd0, 8'h01, 1'b0, 32'h01010301};
    tbl[7]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd1, 8'h04, 1'b0, 32'h01010401};
    tbl[8]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h00, 1'b0, 32'h01000401};
    tbl[9]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hFF, 1'b1, 32'h01FF0401};
    tbl[10] = '{4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1, 32'h01000401};
    tbl[11] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0, 8'h00, 1'b0, 32'h00000000};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h01, 1'b0, 32'h01000000};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 32'h01000000};

    rst_n = 1'b0;
    clr   = 1'b0;
    valid = '0;
    dec   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cnt", cnt, 32'h0);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_value, rsp_wrap}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      valid = tbl[i].valid;
      dec   = tbl[i].dec;
      clr   = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].ready);
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_rsp", i), {rsp_valid, rsp_id, rsp_value, rsp_wrap},
          {tbl[i].rv, tbl[i].id, tbl[i].val, tbl[i].wrap});
    end

    // Asynchronous reset between edges with a response pending.
    @(posedge clk); #1;
    valid = 4'b0001;
    dec   = 4'b0000;
    clr   = 1'b0;
    @(negedge clk);
    chk("ar_ready0", ready, 4'b0001);
    @(posedge clk); #1;
    valid = 4'b1111;
    #2;
    chk("ar_pre_ready", ready, 4'b0010);
    chk("ar_pre_rsp", {rsp_valid, rsp_id, rsp_value}, {1'b1, 2'd0, 8'h01});
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", cnt, 32'h0);
    chk("ar_rsp", {rsp_valid, rsp_id, rsp_value, rsp_wrap}, '0);
    chk("ar_ptr_ready", ready, 4'b0001);
    valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized mixed traffic against a reference model.
    pend = '0; pdec = '0; mptr = 0; gflag = 1'b0; gid = 0;
    exp_rv = 1'b0; exp_id = '0; exp_val = '0; exp_wrap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = '0;
      wt[i]   = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (gflag) pend[gid] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          pdec[i] = 1'($urandom_range(0, 1));
        end
      end
      valid = pend;
      dec   = pdec;
      @(negedge clk);
      eg   = -1;
      expr = '0;
      for (int k = 0; k < 4; k++) begin
        idx = (mptr + k) % 4;
        if (eg < 0 && pend[idx]) eg = idx;
      end
      if (eg >= 0) expr[eg] = 1'b1;
      chk("rnd_ready", ready, expr);
      chk("rnd_cnt", cnt, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
      chk("rnd_rsp", {rsp_valid, rsp_id, rsp_value, rsp_wrap},
          {exp_rv, exp_id, exp_val, exp_wrap});
      for (int i = 0; i < 4; i++) if (pend[i]) wt[i]++;
      if (eg >= 0) begin
        checks++;
        if (wt[eg] > 4) begin
          errors++;
          $display("FAIL rnd_wait req %0d waited %0d cycles, limit 4", eg, wt[eg]);
        end
        wt[eg]   = 0;
        exp_wrap = pdec[eg] ? (mcnt[eg] == 8'h00) : (mcnt[eg] == 8'hFF);
        mcnt[eg] = pdec[eg] ? mcnt[eg] - 8'd1 : mcnt[eg] + 8'd1;
        exp_rv   = 1'b1;
        exp_id   = 2'(eg);
        exp_val  = mcnt[eg];
        mptr     = (eg + 1) % 4;
        gflag    = 1'b1;
        gid      = eg;
      end else begin
        exp_rv   = 1'b0;
        exp_id   = '0;
        exp_val  = '0;
        exp_wrap = 1'b0;
        gflag    = 1'b0;
      end
    end
    @(posedge clk); #1;
    valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
